// File: rtl/axi_dac_mc.sv
// axi_dac_mc: AXI4-Lite controlled multi-channel DAC driver.
//
// A sample FIFO feeds CHANNELS packed lanes of DATA_WIDTH bits to the DAC pins.
// A programmable divider paces playback. Playback either drains the FIFO
// (stream) or replays its contents as a waveform (loop).
//
// Optional feature macro: AXI_DAC_MC_LOOP_EN
//   defined   -> CTL.MODE and the loop index exist (loop playback available)
//   undefined -> CTL.MODE reads 0, writes to it are ignored, stream only
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*        AXI4-Lite write address / data / response
//   s_axi_ar*/r*           AXI4-Lite read address / data
//   dac_clk                DAC latch clock; dac_data is stable at its rising edge
//   dac_data               lane k = dac_data[k*DATA_WIDTH +: DATA_WIDTH]
//
// Handshake semantics: a transfer happens on a rising aclk edge where valid and
// ready are both high. Readies are registered. AW and W are latched
// independently. Once both latches are full, the register or FIFO update and
// the rise of bvalid happen on the same edge. The latches empty on the B
// handshake, so only one write is outstanding at a time. arready is high while
// no read response is pending. rdata is captured at the AR handshake and is
// held with rvalid until rready.
//
// Register map (byte offsets): 0x00 CTL, 0x04 DATA, 0x08 STATUS,
// 0x0C reserved, 0x10 CLK_DIV. Any other offset reads 0, and writes to it are
// ignored.
module axi_dac_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [31:0]                    s_axi_wdata,
  input  logic [3:0]                     s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [31:0]                    s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic                           dac_clk,
  output logic [CHANNELS*DATA_WIDTH-1:0] dac_data
);
  localparam int LW  = CHANNELS * DATA_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LVW = PW + 1;
  localparam int IW  = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] A_CTL    = IW'(0);
  localparam logic [IW-1:0] A_DATA   = IW'(1);
  localparam logic [IW-1:0] A_STATUS = IW'(2);
  localparam logic [IW-1:0] A_CLKDIV = IW'(4);

  if (LW > 32) begin : g_bad_width
    $error("axi_dac_mc: CHANNELS*DATA_WIDTH must not exceed 32");
  end
  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axi_dac_mc: FIFO_DEPTH must be a power of two and at least 4");
  end

  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [31:0]           w_data_q, w_data_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d, rd_mux;
  logic                  en_q, en_d, underrun_q, underrun_d, overflow_q, overflow_d;
  logic [15:0]           clk_div_q, clk_div_d, cnt_q, cnt_d;
  logic                  dac_clk_q, dac_clk_d;
  logic [LW-1:0]         dac_data_q, dac_data_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVW-1:0]        level_q, level_d;
  logic [LW-1:0]         mem [FIFO_DEPTH];
  logic                  mode;
`ifdef AXI_DAC_MC_LOOP_EN
  logic                  mode_q, mode_d;
  logic [PW-1:0]         li_q, li_d, loop_addr;
  assign mode      = mode_q;
  assign loop_addr = rd_ptr_q + li_q;
`else
  assign mode = 1'b0;
`endif

  logic          wr_fire, ctl_wr, fifo_clr, push_req, push_ok, pop, tick, full, empty;
  logic [16:0]   half_d;
  logic [IW-1:0] aw_idx, ar_idx;

  assign aw_idx   = aw_addr_q[ADDR_WIDTH-1:2];
  assign ar_idx   = s_axi_araddr[ADDR_WIDTH-1:2];
  assign wr_fire  = aw_full_q && w_full_q && !bvalid_q;
  assign ctl_wr   = wr_fire && (aw_idx == A_CTL);
  assign fifo_clr = ctl_wr && w_data_q[2];
  assign push_req = wr_fire && (aw_idx == A_DATA);
  assign full     = (level_q == LVW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  // Compare with >= so that lowering CLK_DIV below the running count cannot
  // stall the divider.
  assign tick     = en_q && (cnt_q >= clk_div_q);

  always_comb begin
    rd_mux = '0;
    case (ar_idx)
      A_CTL:    begin rd_mux[0] = en_q; rd_mux[1] = mode; end
      A_DATA:   rd_mux[LW-1:0] = dac_data_q;
      A_STATUS: begin
        rd_mux[15:0] = 16'(level_q);
        rd_mux[16]   = full;
        rd_mux[17]   = empty;
        rd_mux[18]   = underrun_q;
        rd_mux[19]   = overflow_q;
      end
      A_CLKDIV: rd_mux[15:0] = clk_div_q;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    aw_full_d  = aw_full_q;  aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;   w_data_d   = w_data_q;
    bvalid_d   = bvalid_q;   rvalid_d   = rvalid_q;   rdata_d = rdata_q;
    en_d       = en_q;       clk_div_d  = clk_div_q;  cnt_d   = cnt_q;
    dac_data_d = dac_data_q; underrun_d = underrun_q; overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;   rd_ptr_d   = rd_ptr_q;   level_d = level_q;
    pop        = 1'b0;       push_ok    = 1'b0;
`ifdef AXI_DAC_MC_LOOP_EN
    mode_d     = mode_q;     li_d       = li_q;
`endif

    // Write channel latches.
    if (s_axi_awvalid && awready_q) begin aw_full_d = 1'b1; aw_addr_d = s_axi_awaddr; end
    if (s_axi_wvalid && wready_q)   begin w_full_d  = 1'b1; w_data_d  = s_axi_wdata;  end
    if (bvalid_q && s_axi_bready)   begin bvalid_d = 1'b0; aw_full_d = 1'b0; w_full_d = 1'b0; end
    if (wr_fire) bvalid_d = 1'b1;
    awready_d = !aw_full_d;
    wready_d  = !w_full_d;

    // Register writes. Sticky bits are cleared before the set below, so a
    // same-cycle event wins over the clear.
    if (ctl_wr) begin
      en_d = w_data_q[0];
`ifdef AXI_DAC_MC_LOOP_EN
      mode_d = w_data_q[1];
      li_d   = '0;
`endif
    end
    if (wr_fire && (aw_idx == A_STATUS)) begin
      if (w_data_q[18]) underrun_d = 1'b0;
      if (w_data_q[19]) overflow_d = 1'b0;
    end
    if (wr_fire && (aw_idx == A_CLKDIV))
      clk_div_d = (w_data_q[15:0] == 16'd0) ? 16'd1 : w_data_q[15:0];

    // Divider and playback. A clear on the same edge suppresses the tick action.
    cnt_d = (!en_q || tick) ? 16'd0 : cnt_q + 16'd1;
    if (tick && !fifo_clr) begin
      if (empty) begin
        underrun_d = 1'b1;
`ifdef AXI_DAC_MC_LOOP_EN
      end else if (mode) begin
        dac_data_d = mem[loop_addr];
        li_d       = (({1'b0, li_q} + 1'b1) == level_q) ? '0 : li_q + 1'b1;
`endif
      end else begin
        dac_data_d = mem[rd_ptr_q];
        pop        = 1'b1;
      end
    end

    // A push into a full FIFO is dropped even if a pop happens on the same edge.
    if (push_req && !fifo_clr) begin
      if (full) overflow_d = 1'b1;
      else      push_ok    = 1'b1;
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LVW'(push_ok) - LVW'(pop);
    if (fifo_clr) begin
      wr_ptr_d = '0; rd_ptr_d = '0; level_d = '0;
`ifdef AXI_DAC_MC_LOOP_EN
      li_d = '0;
`endif
    end

    // dac_clk is low for the first (D+1)/2 counts of each period. The data
    // update at cnt wrap therefore lands on its falling edge.
    half_d    = ({1'b0, clk_div_d} + 17'd1) >> 1;
    dac_clk_d = en_d && ({1'b0, cnt_d} >= half_d);

    // Read channel.
    if (s_axi_arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0; aw_addr_q <= '0; w_full_q <= 1'b0; w_data_q <= '0;
      awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
      arready_q <= 1'b0; rvalid_q <= 1'b0; rdata_q <= '0;
      en_q <= 1'b0; clk_div_q <= 16'd1; cnt_q <= '0;
      dac_clk_q <= 1'b0; dac_data_q <= '0; underrun_q <= 1'b0; overflow_q <= 1'b0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; level_q <= '0;
`ifdef AXI_DAC_MC_LOOP_EN
      mode_q <= 1'b0; li_q <= '0;
`endif
    end else begin
      aw_full_q <= aw_full_d; aw_addr_q <= aw_addr_d; w_full_q <= w_full_d; w_data_q <= w_data_d;
      awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      arready_q <= arready_d; rvalid_q <= rvalid_d; rdata_q <= rdata_d;
      en_q <= en_d; clk_div_q <= clk_div_d; cnt_q <= cnt_d;
      dac_clk_q <= dac_clk_d; dac_data_q <= dac_data_d;
      underrun_q <= underrun_d; overflow_q <= overflow_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; level_q <= level_d;
`ifdef AXI_DAC_MC_LOOP_EN
      mode_q <= mode_d; li_q <= li_d;
`endif
    end
  end

  // Sample storage needs no reset; only the pointers define its contents.
  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr_q] <= w_data_q[LW-1:0];
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_wstrb, w_data_q, aw_addr_q[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign dac_clk       = dac_clk_q;
  assign dac_data      = dac_data_q;
endmodule

// File: tb/tb_axi_dac_mc.sv
// Testbench for axi_dac_mc (CHANNELS=4, DATA_WIDTH=8, FIFO_DEPTH=16).
// Register reads and DAC samples are checked against expected queues.
// The queues are filled when stimulus is issued and drained by a monitor.
module tb_axi_dac_mc;
  localparam logic [4:0] A_CTL = 5'h00, A_DATA = 5'h04, A_STATUS = 5'h08;
  localparam logic [4:0] A_RES = 5'h0C, A_CLKDIV = 5'h10, A_UNMAP = 5'h14;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic [4:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic        s_axi_bready = 1'b1, s_axi_rready = 1'b1;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic        dac_clk;
  logic [31:0] dac_data;

  axi_dac_mc #(.DATA_WIDTH(8), .CHANNELS(4), .FIFO_DEPTH(16), .ADDR_WIDTH(5)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .dac_clk(dac_clk), .dac_data(dac_data)
  );

  // Clock/reset
  always #5 aclk = ~aclk;

  // Scoreboard state
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, last_rise = 0;
  logic        dac_clk_prev = 1'b0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [31:0] dac_exp_q[$];
  int          dac_per_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge aclk) begin
    logic [31:0] e;
    int          p;
    string       nm;
    cyc++;
    if (dac_clk && !dac_clk_prev) begin
      if (dac_exp_q.size() > 0) begin
        e = dac_exp_q.pop_front();
        p = dac_per_q.pop_front();
        chk("dac_sample", dac_data, e);
        if (p != 0) chk("dac_period", cyc - last_rise, p);
      end
      last_rise = cyc;
    end
    dac_clk_prev = dac_clk;
    if (s_axi_rvalid && s_axi_rready) begin
      if (rd_exp_q.size() > 0) begin
        e  = rd_exp_q.pop_front();
        nm = rd_name_q.pop_front();
        chk(nm, s_axi_rdata, e);
        chk("rresp", {30'd0, s_axi_rresp}, 32'd0);
      end else begin
        chk("unexpected_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
      end
    end
    if (s_axi_bvalid && s_axi_bready) chk("bresp", {30'd0, s_axi_bresp}, 32'd0);
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic axi_issue(input logic [4:0] a, input logic [31:0] d);
    int   n;
    logic aw_hs, w_hs;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata  = d; s_axi_wvalid  = 1'b1;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 50) begin
      @(negedge aclk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid  = 1'b0;
      n++;
    end
    if (s_axi_awvalid || s_axi_wvalid) begin
      fail_now("write_addr_data_handshake");
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    int   n;
    logic got;
    axi_issue(a, d);
    got = 1'b0; n = 0;
    while (!got && n < 50) begin
      @(negedge aclk);
      got = s_axi_bvalid;
      @(posedge aclk); #1;
      n++;
    end
    if (!got) fail_now("write_response");
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp, input string name);
    int   n;
    logic hs, got;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge aclk);
      hs = s_axi_arready;
      @(posedge aclk); #1;
      n++;
    end
    s_axi_arvalid = 1'b0;
    if (!hs) fail_now({name, "_ar"});
    got = 1'b0; n = 0;
    while (hs && !got && n < 50) begin
      @(negedge aclk);
      got = s_axi_rvalid;
      @(posedge aclk); #1;
      n++;
    end
    if (hs && !got) fail_now({name, "_r"});
  endtask

  task automatic push_dac(input logic [31:0] d, input int period);
    dac_exp_q.push_back(d);
    dac_per_q.push_back(period);
  endtask

  task automatic wait_dac_drain(input int bound);
    int n;
    n = 0;
    while (dac_exp_q.size() > 0 && n < bound) begin
      @(posedge aclk); #1;
      n++;
    end
    if (dac_exp_q.size() > 0) begin
      fail_now("dac_samples_missing");
      dac_exp_q.delete();
      dac_per_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic got;

    // Reset state, sampled while reset is held.
    repeat (3) @(negedge aclk);
    chk("rst_dac_clk", {31'd0, dac_clk}, 32'd0);
    chk("rst_dac_data", dac_data, 32'd0);
    chk("rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    chk("rst_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    aresetn = 1'b1;
    idle(3);

    // Register reset values and unmapped space.
    axi_read(A_CTL,    32'h0000_0000, "ctl_reset");
    axi_read(A_STATUS, 32'h0002_0000, "status_reset");
    axi_read(A_CLKDIV, 32'h0000_0001, "clkdiv_reset");
    axi_read(A_RES,    32'h0000_0000, "reserved_read");
    axi_read(A_UNMAP,  32'h0000_0000, "unmapped_read");
    axi_read(A_DATA,   32'h0000_0000, "data_reset");

    // Stream, D=3. The first rising edge shows stale data, then 0x5A, then
    // 0x6C, then an underrun holds 0x6C.
    axi_write(A_CLKDIV, 32'd3);
    axi_write(A_DATA, 32'h5A);
    axi_write(A_DATA, 32'h6C);
    push_dac(32'h0, 0); push_dac(32'h5A, 4); push_dac(32'h6C, 4); push_dac(32'h6C, 4);
    axi_write(A_CTL, 32'h1);
    wait_dac_drain(200);
    axi_read(A_STATUS, 32'h0006_0000, "status_underrun");
    axi_read(A_DATA, 32'h0000_006C, "data_hold_underrun");
    axi_write(A_CTL, 32'h0);
    axi_write(A_STATUS, 32'h0004_0000);
    axi_read(A_STATUS, 32'h0002_0000, "status_underrun_cleared");

    // Four packed lanes, D=1: lane0=0x44 ... lane3=0x11.
    axi_write(A_CLKDIV, 32'd1);
    axi_write(A_DATA, 32'h1122_3344);
    push_dac(32'h6C, 0); push_dac(32'h1122_3344, 2);
    axi_write(A_CTL, 32'h1);
    wait_dac_drain(100);
    axi_write(A_CTL, 32'h0);
    axi_read(A_DATA, 32'h1122_3344, "data_four_lanes");
    axi_read(A_STATUS, 32'h0006_0000, "status_empty_after_lanes");
    axi_write(A_STATUS, 32'h0004_0000);

    // Overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) axi_write(A_DATA, 32'(i + 1));
    axi_read(A_STATUS, 32'h0009_0010, "status_full_overflow");
    axi_write(A_STATUS, 32'h0008_0000);
    axi_read(A_STATUS, 32'h0001_0010, "status_overflow_cleared");
    axi_write(A_CTL, 32'h4);
    axi_read(A_STATUS, 32'h0002_0000, "status_after_clr");
    axi_read(A_CTL, 32'h0, "ctl_clr_reads_0");

    // FIFO_CLR during stream playback, D=31.
    axi_write(A_CLKDIV, 32'd31);
    for (int i = 0; i < 5; i++) axi_write(A_DATA, 32'hA1 + 32'(i));
    push_dac(32'h1122_3344, 0); push_dac(32'hA1, 32);
    axi_write(A_CTL, 32'h1);
    wait_dac_drain(400);
    axi_write(A_CTL, 32'h5);
    axi_read(A_STATUS, 32'h0002_0000, "status_clr_playback");
    push_dac(32'hA1, 32);
    wait_dac_drain(400);
    axi_read(A_STATUS, 32'h0006_0000, "status_underrun_after_clr");
    axi_read(A_DATA, 32'h0000_00A1, "data_held_after_clr");
    axi_write(A_CTL, 32'h0);
    axi_write(A_STATUS, 32'h000C_0000);

    // CLK_DIV of 0 is stored as 1.
    axi_write(A_CLKDIV, 32'd0);
    axi_read(A_CLKDIV, 32'h1, "clkdiv_zero_is_one");

`ifdef AXI_DAC_MC_LOOP_EN
    // Loop mode, D=1: 1,2,3,1,2,3 with the FIFO left intact.
    axi_write(A_DATA, 32'h1);
    axi_write(A_DATA, 32'h2);
    axi_write(A_DATA, 32'h3);
    push_dac(32'hA1, 0);
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= 3; k++) push_dac(32'(k), 2);
    axi_write(A_CTL, 32'h3);
    wait_dac_drain(100);
    axi_write(A_CTL, 32'h0);
    axi_read(A_STATUS, 32'h0000_0003, "status_loop_level");
    axi_write(A_CTL, 32'h4);
`else
    // Without loop support MODE is not writable.
    axi_write(A_CTL, 32'h2);
    axi_read(A_CTL, 32'h0, "ctl_mode_absent");
`endif

    // Asynchronous reset with a pending write response.
    axi_write(A_CLKDIV, 32'd5);
    axi_write(A_DATA, 32'h77);
    axi_write(A_CTL, 32'h1);
    idle(12);
    axi_read(A_DATA, 32'h0000_0077, "data_before_reset");
    s_axi_bready = 1'b0;
    axi_issue(A_CLKDIV, 32'd9);
    got = 1'b0; n = 0;
    while (!got && n < 50) begin
      @(negedge aclk);
      got = s_axi_bvalid;
      n++;
    end
    if (!got) fail_now("pending_bvalid");
    aresetn = 1'b0;
    #1;
    chk("async_rst_dac_clk", {31'd0, dac_clk}, 32'd0);
    chk("async_rst_dac_data", dac_data, 32'd0);
    chk("async_rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    s_axi_bready = 1'b1;
    idle(3);
    axi_read(A_CLKDIV, 32'h1, "clkdiv_after_reset");
    axi_read(A_STATUS, 32'h0002_0000, "status_after_reset");
    axi_read(A_CTL, 32'h0, "ctl_after_reset");

    // Final report
    idle(5);
    if (rd_exp_q.size() != 0) fail_now("read_responses_missing");
    if (dac_exp_q.size() != 0) fail_now("dac_samples_missing_end");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
